// File: rtl/shader_pkg.sv
// Shared types for the face sequencer: word offsets within a face record,
// the held face register layout, and the sequencer state encoding.
package shader_pkg;

  localparam int FACE_WORDS = 10;

  // Word order inside one 10-word face record in face memory.
  typedef enum logic [3:0] {
    W_V1X, W_V1Y, W_V1Z,
    W_V2X, W_V2Y, W_V2Z,
    W_V3X, W_V3Y, W_V3Z,
    W_COLOR
  } word_off_t;

  typedef struct packed {
    logic [15:0] v1x, v1y, v1z;
    logic [15:0] v2x, v2y, v2z;
    logic [15:0] v3x, v3y, v3z;
    logic [15:0] color;
  } face_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_FIRE, S_WAIT, S_FIN
  } seq_state_t;

endpackage

// File: rtl/face_fetcher.sv
// Face-record fetcher.
//  While go is high, issues one read per cycle at base+k (k = 0..9) and
//  tracks each read through a MEM_LAT-deep valid/offset pipe so the
//  returning word lands in the matching field of the held face register.
// Ports:
//  clk, reset     clock, synchronous active-high reset (clears pipe + face)
//  go             fetch enable (high for exactly the 10 issue cycles)
//  base           word address of face record
//  mem_rd/addr    face-memory read strobe and address
//  mem_data       read data, valid MEM_LAT cycles after mem_rd
//  face           held face record
//  last           high on the issue cycle of the colour word
//  loaded         high on the cycle the colour word is captured
module face_fetcher
  import shader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output face_t             face,
  output logic              last,
  output logic              loaded
);

  word_off_t k;
  logic      [MEM_LAT:1] vld_pipe;
  word_off_t off_pipe [MEM_LAT:1];

  assign mem_rd   = go;
  assign mem_addr = base + {{(ADDR_W-4){1'b0}}, k};
  assign last     = go && (k == W_COLOR);
  assign loaded   = vld_pipe[MEM_LAT] && (off_pipe[MEM_LAT] == W_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      k <= W_V1X;
    end else if (go && !last) begin
      k <= word_off_t'(k + 4'd1);
    end else begin
      k <= W_V1X;
    end
  end

  // Reset flushes the pipe so reads still in flight are never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= MEM_LAT; i++) off_pipe[i] <= W_V1X;
    end else begin
      vld_pipe[1] <= go;
      off_pipe[1] <= k;
      for (int i = 2; i <= MEM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        off_pipe[i] <= off_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      face <= '0;
    end else if (vld_pipe[MEM_LAT]) begin
      case (off_pipe[MEM_LAT])
        W_V1X:   face.v1x   <= mem_data;
        W_V1Y:   face.v1y   <= mem_data;
        W_V1Z:   face.v1z   <= mem_data;
        W_V2X:   face.v2x   <= mem_data;
        W_V2Y:   face.v2y   <= mem_data;
        W_V2Z:   face.v2z   <= mem_data;
        W_V3X:   face.v3x   <= mem_data;
        W_V3Y:   face.v3y   <= mem_data;
        W_V3Z:   face.v3z   <= mem_data;
        default: face.color <= mem_data;
      endcase
    end
  end

endmodule

// File: rtl/face_sequencer.sv
// Frame-level shader scheduler.
//  On an accepted frame_start, walks faces 0..num_faces-1: fetches each
//  10-word record, pulses start, waits for a rising edge of done, then moves
//  on. frame_done pulses once at the end of the pass.
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  frame_start/num_faces pass request and face count (sampled on accept)
//  mem_rd/mem_addr/data  face-memory read port
//  v1*..v3*, pixel_color held face to shader
//  start / done          shader start pulse / done level
//  busy, face_idx        pass in progress, current face
//  frame_done            end-of-pass pulse
//  overrun               sticky: frame_start seen while busy
module face_sequencer
  import shader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int FACE_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [FACE_W-1:0] num_faces,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       v1x, v1y, v1z,
  output logic [15:0]       v2x, v2y, v2z,
  output logic [15:0]       v3x, v3y, v3z,
  output logic [15:0]       pixel_color,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic [FACE_W-1:0] face_idx,
  output logic              frame_done,
  output logic              overrun
);

  seq_state_t        state, state_nx;
  logic [FACE_W-1:0] count;
  logic [ADDR_W-1:0] base;
  logic              done_q;
  logic              done_rise, last_face, fetch_last, loaded;
  face_t             face;

  face_fetcher #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) u_fetch (
    .clk      (clk),
    .reset    (reset),
    .go       (state == S_FETCH),
    .base     (base),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .face     (face),
    .last     (fetch_last),
    .loaded   (loaded)
  );

  assign {v1x, v1y, v1z} = {face.v1x, face.v1y, face.v1z};
  assign {v2x, v2y, v2z} = {face.v2x, face.v2y, face.v2z};
  assign {v3x, v3y, v3z} = {face.v3x, face.v3y, face.v3z};
  assign pixel_color     = face.color;

  // A done level already high when WAIT is entered must not count.
  assign done_rise = done && !done_q;
  assign last_face = ({1'b0, face_idx} + 1'b1) == {1'b0, count};
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (frame_start) state_nx = (num_faces == '0) ? S_FIN : S_FETCH;
      S_FETCH: if (fetch_last) state_nx = S_DRAIN;
      S_DRAIN: if (loaded) state_nx = S_FIRE;
      S_FIRE: begin
        start    = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT:  if (done_rise) state_nx = last_face ? S_FIN : S_FETCH;
      S_FIN: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      face_idx <= '0;
      base     <= '0;
      done_q   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= done;
      // FIN still counts as busy, so a same-cycle frame_start is flagged.
      if (frame_start && busy) overrun <= 1'b1;
      if (state == S_IDLE && frame_start) begin
        count    <= num_faces;
        face_idx <= '0;
        base     <= '0;
      end else if (state == S_WAIT && done_rise && !last_face) begin
        face_idx <= face_idx + 1'b1;
        base     <= base + ADDR_W'(FACE_WORDS);
      end
    end
  end

endmodule

// File: tb/tb_face_sequencer.sv
module tb_face_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  // MEM_LAT=1 instance
  logic        frame_start = 1'b0, done = 1'b0, mem_rd, start, busy, frame_done, overrun;
  logic [7:0]  num_faces = '0, face_idx;
  logic [11:0] mem_addr;
  logic [15:0] mem_data, v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, pixel_color;

  // MEM_LAT=3 instance
  logic        fs3 = 1'b0, done3 = 1'b0, mem_rd3, start3, busy3, frame_done3, overrun3;
  logic [7:0]  nf3 = '0, face_idx3;
  logic [11:0] mem_addr3;
  logic [15:0] mem_data3, a1x, a1y, a1z, a2x, a2y, a2z, a3x, a3y, a3z, color3;

  logic        auto_done = 1'b1;
  int          dly = 5;

  face_sequencer #(.ADDR_W(12), .FACE_W(8), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .num_faces(num_faces),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .v1x(v1x), .v1y(v1y), .v1z(v1z), .v2x(v2x), .v2y(v2y), .v2z(v2z),
    .v3x(v3x), .v3y(v3y), .v3z(v3z), .pixel_color(pixel_color),
    .start(start), .done(done), .busy(busy), .face_idx(face_idx),
    .frame_done(frame_done), .overrun(overrun)
  );

  face_sequencer #(.ADDR_W(12), .FACE_W(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .frame_start(fs3), .num_faces(nf3),
    .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_data(mem_data3),
    .v1x(a1x), .v1y(a1y), .v1z(a1z), .v2x(a2x), .v2y(a2y), .v2z(a2z),
    .v3x(a3x), .v3y(a3y), .v3z(a3z), .pixel_color(color3),
    .start(start3), .done(done3), .busy(busy3), .face_idx(face_idx3),
    .frame_done(frame_done3), .overrun(overrun3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Face memory: face 0 is the reference record, faces 1..2 are 0xF000|addr.
  logic [15:0] mem [0:63];
  initial begin
    logic [15:0] f0 [0:9];
    f0 = '{16'h2800, 16'h1E00, 16'h0186, 16'h27FA, 16'h19D4,
           16'h0186, 16'h2D0C, 16'h19FC, 16'h0186, 16'h0001};
    for (int a = 0; a < 64; a++) mem[a] = (a < 10) ? f0[a] : (16'hF000 | 16'(a));
  end

  logic [15:0] rq1, rq3a, rq3b, rq3c;
  always @(posedge clk) begin
    rq1  <= mem_rd  ? mem[mem_addr[5:0]]  : 16'hBAD0;
    rq3a <= mem_rd3 ? mem[mem_addr3[5:0]] : 16'hBAD3;
    rq3b <= rq3a;
    rq3c <= rq3b;
  end
  assign mem_data  = rq1;
  assign mem_data3 = rq3c;

  // Shader models: raise done dly cycles after start, hold 2 cycles.
  always @(negedge clk) if (start && auto_done) begin
    repeat (dly) @(posedge clk);
    #1 done = 1'b1;
    repeat (2) @(posedge clk);
    #1 done = 1'b0;
  end
  always @(negedge clk) if (start3 && auto_done) begin
    repeat (dly) @(posedge clk);
    #1 done3 = 1'b1;
    repeat (2) @(posedge clk);
    #1 done3 = 1'b0;
  end

  typedef struct { int cyc; logic [7:0] idx; logic [159:0] w; } exp_t;
  exp_t q_start[$], q_start3[$];
  int   q_addr[$], q_fd[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [159:0] face_words(input int f);
    logic [159:0] w = '0;
    for (int k = 0; k < 10; k++) w = {w[143:0], mem[f*10+k]};
    return w;
  endfunction

  function automatic exp_t mk(input int c, input int f);
    exp_t e;
    e.cyc = c; e.idx = 8'(f); e.w = face_words(f);
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mem_rd) begin
      if (q_addr.size() == 0) check("unexpected_mem_rd", {148'd0, mem_addr}, '1);
      else check("mem_addr", {148'd0, mem_addr}, 160'(q_addr.pop_front()));
    end
    if (start) begin
      if (q_start.size() == 0) check("unexpected_start", 160'(cyc), '1);
      else begin
        e = q_start.pop_front();
        check("start_cycle", 160'(cyc), 160'(e.cyc));
        check("start_face_idx", {152'd0, face_idx}, {152'd0, e.idx});
        check("start_face_regs", {v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, pixel_color}, e.w);
      end
    end
    if (frame_done) begin
      if (q_fd.size() == 0) check("unexpected_frame_done", 160'(cyc), '1);
      else check("frame_done_cycle", 160'(cyc), 160'(q_fd.pop_front()));
    end
    if (start3) begin
      if (q_start3.size() == 0) check("unexpected_start3", 160'(cyc), '1);
      else begin
        e = q_start3.pop_front();
        check("start3_cycle", 160'(cyc), 160'(e.cyc));
        check("start3_face_idx", {152'd0, face_idx3}, {152'd0, e.idx});
        check("start3_face_regs", {a1x, a1y, a1z, a2x, a2y, a2z, a3x, a3y, a3z, color3}, e.w);
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask
  task automatic wait_to(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic push_addrs(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) q_addr.push_back(a);
  endtask
  task automatic pass(input int t, input logic [7:0] n);
    at(t); frame_start = 1'b1; num_faces = n;
    at(t + 1); frame_start = 1'b0;
  endtask
  task automatic drained(input string name);
    check(name, 160'(q_addr.size() + q_start.size() + q_fd.size() + q_start3.size()), 160'd0);
  endtask

  logic [183:0] all_out;
  assign all_out = {mem_rd, mem_addr, v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z,
                    pixel_color, start, busy, face_idx, frame_done, overrun};

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_out[159:0], '0);
    check("reset_outputs_hi", {136'd0, all_out[183:160]}, '0);

    // 1 face, reference record, done edge 28 cycles after start
    t = cyc + 2; dly = 28;
    push_addrs(0, 9); q_start.push_back(mk(t + 12, 0)); q_fd.push_back(t + 41);
    pass(t, 8'd1);
    wait_to(t + 12);
    check("t1_v1x", {144'd0, v1x}, {144'd0, 16'h2800});
    check("t1_v3y", {144'd0, v3y}, {144'd0, 16'h19FC});
    check("t1_color", {144'd0, pixel_color}, {144'd0, 16'h0001});
    check("t1_busy", {159'd0, busy}, 160'd1);
    wait_to(t + 45);
    drained("t1_drained");
    check("t1_busy_end", {159'd0, busy}, 160'd0);

    // 3 faces
    t = cyc + 2; dly = 5;
    push_addrs(0, 29);
    q_start.push_back(mk(t + 12, 0)); q_start.push_back(mk(t + 29, 1));
    q_start.push_back(mk(t + 46, 2)); q_fd.push_back(t + 52);
    pass(t, 8'd3);
    wait_to(t + 56);
    drained("t2_drained");

    // 0 faces: straight to FIN
    t = cyc + 2;
    q_fd.push_back(t + 1);
    pass(t, 8'd0);
    wait_to(t + 1);
    check("t3_busy_hi", {159'd0, busy}, 160'd1);
    wait_to(t + 2);
    check("t3_busy_lo", {159'd0, busy}, 160'd0);
    wait_to(t + 5);
    drained("t3_drained");

    // done held high across FIRE/WAIT entry; frame_start mid-pass
    t = cyc + 2; auto_done = 1'b0;
    push_addrs(0, 9); q_start.push_back(mk(t + 12, 0)); q_fd.push_back(t + 23);
    pass(t, 8'd1);
    at(t + 5); done = 1'b1;
    wait_to(t + 14);
    check("t4_overrun_clear", {159'd0, overrun}, 160'd0);
    at(t + 15); frame_start = 1'b1; num_faces = 8'd3;
    at(t + 16); frame_start = 1'b0;
    wait_to(t + 17);
    check("t4_overrun_set", {159'd0, overrun}, 160'd1);
    at(t + 20); done = 1'b0;
    at(t + 22); done = 1'b1;
    at(t + 24); done = 1'b0;
    wait_to(t + 28);
    drained("t4_drained");
    check("t4_overrun_sticky", {159'd0, overrun}, 160'd1);
    auto_done = 1'b1;

    // reset during DRAIN of face 1, then restart
    t = cyc + 2; dly = 5;
    push_addrs(0, 19); q_start.push_back(mk(t + 12, 0));
    pass(t, 8'd3);
    at(t + 28); reset = 1'b1;
    at(t + 29); reset = 1'b0;
    wait_to(t + 29);
    check("t5_reset_outputs", all_out[159:0], '0);
    check("t5_reset_outputs_hi", {136'd0, all_out[183:160]}, '0);
    drained("t5_abandon");
    t = t + 32;
    push_addrs(0, 9); q_start.push_back(mk(t + 12, 0)); q_fd.push_back(t + 18);
    pass(t, 8'd1);
    wait_to(t + 22);
    drained("t5_restart");

    // MEM_LAT=3 instance, 2 faces
    t = cyc + 2;
    q_start3.push_back(mk(t + 14, 0)); q_start3.push_back(mk(t + 33, 1));
    at(t); fs3 = 1'b1; nf3 = 8'd2;
    at(t + 1); fs3 = 1'b0;
    wait_to(t + 39);
    check("t6_frame_done3", {159'd0, frame_done3}, 160'd1);
    wait_to(t + 40);
    check("t6_frame_done3_pulse", {159'd0, frame_done3}, 160'd0);
    drained("t6_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
